// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock through a
// ripple of full-subtractor cells, with valid/ready handshakes on both sides.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_subtractor: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]       a_sh, b_sh;
  logic                   borrow;
  logic [CW-1:0]          count;
  logic                   a_msb, b_msb;
  logic [DIGIT-1:0]       dig;
  logic                   cell_bout;
  logic [WIDTH+DIGIT-1:0] diff_cat;
  logic [WIDTH-1:0]       diff_shift;
  logic                   accept, last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned and a latch is inferred.
  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_next = RUN;
      end
      RUN: begin
        if (count == LAST) state_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && start_valid;
  assign last   = (state == RUN) && (count == LAST);

  // Ripple of DIGIT full-subtractor cells on the low bits of the operands.
  always_comb begin
    logic br;
    br  = borrow;
    dig = '0;
    for (int i = 0; i < DIGIT; i++) begin
      dig[i] = a_sh[i] ^ b_sh[i] ^ br;
      br     = (~a_sh[i] & b_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & br);
    end
    cell_bout = br;
  end

  // New digits enter at the top; after N steps the first digit sits at the LSB.
  assign diff_cat   = {dig, diff};
  assign diff_shift = diff_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      borrow <= 1'b0;
      count  <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      borrow <= bin;
      count  <= '0;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
    end else if (state == RUN) begin
      diff   <= diff_shift;
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      borrow <= cell_bout;
      count  <= count + CW'(1);
      if (last) begin
        bout <= cell_bout;
        zero <= (diff_shift == '0);
        ovf  <= (a_msb != b_msb) && (diff_shift[WIDTH-1] != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: a 16/4 instance for the main cases and
// an 8/8 instance for single-cycle, back-to-back randomised operation.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        s_start_valid, s_start_ready, s_bin, s_res_valid, s_res_ready;
  logic [15:0] s_a, s_b, s_diff;
  logic        s_bout, s_zero, s_ovf;

  logic        t_start_valid, t_start_ready, t_bin, t_res_valid, t_res_ready;
  logic [7:0]  t_a, t_b, t_diff;
  logic        t_bout, t_zero, t_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst),
    .start_valid(s_start_valid), .start_ready(s_start_ready),
    .a(s_a), .b(s_b), .bin(s_bin),
    .res_valid(s_res_valid), .res_ready(s_res_ready),
    .diff(s_diff), .bout(s_bout), .zero(s_zero), .ovf(s_ovf)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst),
    .start_valid(t_start_valid), .start_ready(t_start_ready),
    .a(t_a), .b(t_b), .bin(t_bin),
    .res_valid(t_res_valid), .res_ready(t_res_ready),
    .diff(t_diff), .bout(t_bout), .zero(t_zero), .ovf(t_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a 16-bit operation and leave the DUT in DONE with outputs checked.
  task automatic op16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                      input logic binv, input logic [15:0] ed, input logic eb,
                      input logic ez, input logic eo);
    int lat;
    s_a = av; s_b = bv; s_bin = binv; s_start_valid = 1'b1;
    tick();
    s_start_valid = 1'b0;
    s_a = 16'hDEAD; s_b = 16'hBEEF; s_bin = ~binv;
    lat = 0;
    while (!s_res_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " diff"}, 32'(s_diff), 32'(ed));
    check({tag, " bout"}, 32'(s_bout), 32'(eb));
    check({tag, " zero"}, 32'(s_zero), 32'(ez));
    check({tag, " ovf"}, 32'(s_ovf), 32'(eo));
    check({tag, " start_ready in done"}, 32'(s_start_ready), 32'd0);
  endtask

  task automatic hs16(input string tag);
    s_res_ready = 1'b1;
    tick();
    s_res_ready = 1'b0;
    check({tag, " res_valid after hs"}, 32'(s_res_valid), 32'd0);
    check({tag, " start_ready after hs"}, 32'(s_start_ready), 32'd1);
  endtask

  // One full 8-bit transaction from IDLE back to IDLE, checked against a golden model.
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic binv);
    int lat;
    logic [8:0] full;
    logic [7:0] ed;
    logic       eo;
    full = {1'b0, av} - {1'b0, bv} - 9'(binv);
    ed   = full[7:0];
    eo   = (av[7] != bv[7]) && (ed[7] != av[7]);
    t_a = av; t_b = bv; t_bin = binv; t_start_valid = 1'b1;
    tick();
    t_start_valid = 1'b0;
    t_a = ~av; t_b = ~bv;
    lat = 0;
    while (!t_res_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd1);
    check({tag, " no overlap"}, 32'(t_start_ready & t_res_valid), 32'd0);
    check({tag, " diff"}, 32'(t_diff), 32'(ed));
    check({tag, " bout"}, 32'(t_bout), 32'(full[8]));
    check({tag, " zero"}, 32'(t_zero), 32'(ed == 8'd0));
    check({tag, " ovf"}, 32'(t_ovf), 32'(eo));
    t_res_ready = 1'b1;
    tick();
    t_res_ready = 1'b0;
    check({tag, " idle after hs"}, 32'({t_start_ready, t_res_valid}), 32'b10);
  endtask

  initial begin
    rst = 1'b1;
    s_start_valid = 1'b0; s_res_ready = 1'b0; s_a = '0; s_b = '0; s_bin = 1'b0;
    t_start_valid = 1'b0; t_res_ready = 1'b0; t_a = '0; t_b = '0; t_bin = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("reset start_ready", 32'(s_start_ready), 32'd1);
    check("reset res_valid", 32'(s_res_valid), 32'd0);
    check("reset flags", 32'({s_diff, s_bout, s_zero, s_ovf}), 32'd0);
    check("reset8 handshake", 32'({t_start_ready, t_res_valid}), 32'b10);

    op16("t1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    hs16("t1");
    op16("t2a", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    hs16("t2a");
    op16("t2b", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    hs16("t2b");
    op16("t3a", 16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    hs16("t3a");
    op16("t3b", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    hs16("t3b");
    op16("wrap", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
    hs16("wrap");

    // Backpressure: result held while start_valid pulses are ignored.
    op16("bp", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      s_start_valid = 1'b1; s_a = 16'h5555; s_b = 16'h0001; s_bin = 1'b0;
      tick();
      check("bp res_valid held", 32'(s_res_valid), 32'd1);
      check("bp start_ready low", 32'(s_start_ready), 32'd0);
      check("bp diff stable", 32'({s_diff, s_bout, s_zero, s_ovf}), 32'({16'h1000, 3'b000}));
    end
    s_start_valid = 1'b0;
    hs16("bp");
    check("bp diff held in idle", 32'(s_diff), 32'h1000);
    tick();
    check("bp no new op", 32'({s_start_ready, s_res_valid}), 32'b10);

    // Leave bout/ovf set, then abort an operation mid-flight with reset.
    op16("pre_rst", 16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);
    hs16("pre_rst");
    s_a = 16'hFFFF; s_b = 16'h0000; s_bin = 1'b0; s_start_valid = 1'b1;
    tick();
    s_start_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort start_ready", 32'(s_start_ready), 32'd1);
    check("abort res_valid", 32'(s_res_valid), 32'd0);
    check("abort outputs", 32'({s_diff, s_bout, s_zero, s_ovf}), 32'd0);
    op16("post_rst", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);
    hs16("post_rst");

    // Single-cycle configuration: corners, then back-to-back random operands.
    op8("w8 wrap", 8'h00, 8'hFF, 1'b1);
    op8("w8 eq", 8'h5A, 8'h5A, 1'b1);
    op8("w8 ovf", 8'h80, 8'h01, 1'b0);
    for (int i = 0; i < 50; i++) begin
      op8("w8 rand", 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
